// File: rtl/score_pkg.sv
// score_pkg: shared types, constants and helpers for the score_board_n leaderboard.
package score_pkg;

  typedef enum logic [2:0] {IDLE, CMP, SHIFT, ROM_WAIT, RESP} state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam int         IID_NONE = 0;

  function automatic int rank_w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction

  function automatic logic bcd_valid(input logic [63:0] v, input int digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 16; i++)
      if (i < digits && v[4*i+:4] > BCD_MAX) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/rank_compare.sv
// rank_compare: parallel packed-BCD ">=" search for the insert rank of a new score.
module rank_compare #(
  parameter int ENTRIES = 4,
  parameter int SW = 8,
  parameter int RW = 2
) (
  input  logic [ENTRIES-1:0] valid_i,
  input  logic [SW-1:0]      scores_i [ENTRIES],
  input  logic [SW-1:0]      score_i,
  output logic               found_o,
  output logic [RW-1:0]      rank_o
);

  // Valid packed BCD orders like unsigned binary, so a plain compare suffices; lowest matching rank wins.
  always_comb begin
    found_o = 1'b0;
    rank_o = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!valid_i[i] || score_i >= scores_i[i]) begin
        found_o = 1'b1;
        rank_o = RW'(i);
      end
  end

endmodule

// File: rtl/score_board_n.sv
// score_board_n: sorted leaderboard of the best non-guest scores with UID ROM lookup on query.
// Define SCOREBOARD_CLEAR_EN to add the clr_req table-clear input.
module score_board_n
  import score_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int SCORE_DIGITS = 2,
  parameter int IID_W = 3,
  parameter int UID_DIGITS = 4,
  parameter int ROM_LAT = 4,
  localparam int RANK_W = rank_w(ENTRIES),
  localparam int SW = 4 * SCORE_DIGITS,
  localparam int UW = 4 * UID_DIGITS
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SCOREBOARD_CLEAR_EN
  input  logic              clr_req,
`endif
  input  logic              sub_valid,
  output logic              sub_ready,
  input  logic              sub_guest,
  input  logic [IID_W-1:0]  sub_iid,
  input  logic [SW-1:0]     sub_score,
  output logic              ins_done,
  output logic              ins_placed,
  output logic [RANK_W-1:0] ins_rank,
  input  logic              qry_valid,
  output logic              qry_ready,
  input  logic [RANK_W-1:0] qry_rank,
  output logic [IID_W-1:0]  rom_addr,
  input  logic [UW-1:0]     rom_data,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [SW-1:0]     rsp_score,
  output logic [UW-1:0]     rsp_uid
);

  state_e             state_q, state_d;
  logic [SW-1:0]      score_q [ENTRIES];
  logic [IID_W-1:0]   iid_q [ENTRIES];
  logic [ENTRIES-1:0] valid_q;
  logic [SW-1:0]      new_score_q, snap_score_q, rsp_score_q, q_score;
  logic [IID_W-1:0]   new_iid_q, rom_addr_q, q_iid;
  logic [RANK_W-1:0]  rank_q, cmp_rank;
  logic [UW-1:0]      rsp_uid_q;
  logic [3:0]         cnt_q;
  logic               rej_q, snap_hit_q, q_hit, found, clr, idle, sub_acc, qry_acc;

`ifdef SCOREBOARD_CLEAR_EN
  assign clr = clr_req && state_q == IDLE;
`else
  assign clr = 1'b0;
`endif
  assign idle = state_q == IDLE && !clr;
  assign sub_acc = idle && sub_valid;
  assign qry_acc = idle && !sub_valid && qry_valid;

  rank_compare #(.ENTRIES(ENTRIES), .SW(SW), .RW(RANK_W)) u_cmp (
    .valid_i (valid_q),
    .scores_i(score_q),
    .score_i (new_score_q),
    .found_o (found),
    .rank_o  (cmp_rank)
  );

  // Entry addressed by the incoming query; out-of-range ranks read as unoccupied.
  always_comb begin
    q_hit = 1'b0;
    q_score = '0;
    q_iid = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (qry_rank == RANK_W'(i) && valid_q[i]) begin
        q_hit = 1'b1;
        q_score = score_q[i];
        q_iid = iid_q[i];
      end
  end

  // State register.
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;

  // Next state: submission beats query in IDLE; rejects and misses finish straight from CMP.
  always_comb
    state_d = state_q == IDLE ? (sub_acc ? CMP : qry_acc ? (q_hit ? ROM_WAIT : RESP) : IDLE)
            : state_q == CMP ? (rej_q || !found ? IDLE : SHIFT)
            : state_q == ROM_WAIT ? (cnt_q == 4'(ROM_LAT - 1) ? RESP : ROM_WAIT)
            : IDLE;

  // Handshakes, pulses and response fields; response values hold their last pulse between pulses.
  always_comb begin
    sub_ready = idle;
    qry_ready = idle && !sub_valid;
    ins_done = (state_q == CMP && (rej_q || !found)) || state_q == SHIFT;
    ins_placed = state_q == SHIFT;
    ins_rank = rank_q;
    rom_addr = rom_addr_q;
    rsp_valid = state_q == RESP;
    rsp_hit = state_q == RESP && snap_hit_q;
    rsp_score = state_q == RESP ? snap_score_q : rsp_score_q;
    rsp_uid = state_q == RESP ? (snap_hit_q ? rom_data : '0) : rsp_uid_q;
  end

  // Leaderboard table, captured submission/query fields and held response values.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        score_q[i] <= '0;
        iid_q[i] <= '0;
      end
      valid_q <= '0;
      new_score_q <= '0;
      new_iid_q <= '0;
      rej_q <= 1'b0;
      rank_q <= '0;
      snap_hit_q <= 1'b0;
      snap_score_q <= '0;
      rom_addr_q <= '0;
      cnt_q <= '0;
      rsp_score_q <= '0;
      rsp_uid_q <= '0;
    end else begin
      if (clr) valid_q <= '0;
      if (sub_acc) begin
        new_score_q <= sub_score;
        new_iid_q <= sub_iid;
        rej_q <= sub_guest || sub_iid == IID_W'(IID_NONE) || !bcd_valid(64'(sub_score), SCORE_DIGITS);
      end
      if (state_q == CMP && !rej_q && found) rank_q <= cmp_rank;
      if (state_q == SHIFT) begin
        for (int i = 1; i < ENTRIES; i++)
          if (RANK_W'(i) > rank_q) begin
            score_q[i] <= score_q[i-1];
            iid_q[i] <= iid_q[i-1];
            valid_q[i] <= valid_q[i-1];
          end
        score_q[rank_q] <= new_score_q;
        iid_q[rank_q] <= new_iid_q;
        valid_q[rank_q] <= 1'b1;
      end
      if (qry_acc) begin
        snap_hit_q <= q_hit;
        snap_score_q <= q_score;
        cnt_q <= '0;
        if (q_hit) rom_addr_q <= q_iid;
      end
      if (state_q == ROM_WAIT) cnt_q <= cnt_q + 4'd1;
      if (state_q == RESP) begin
        rsp_score_q <= rsp_score;
        rsp_uid_q <= rsp_uid;
      end
    end

endmodule
